max7219_ctrl: RTL and testbench
===============================

MAX7219_CTRL -- requirements
Module: max7219_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10, meaning clk cycles per SPI bit (even, >=4).
REQ-002 SHALL have parameter BRIGHTNESS, default 12, meaning init intensity value (0-15).
REQ-003 SHALL have parameter LOAD_HOLD, default 4, meaning clk cycles max_load stays high after each frame.
REQ-004 SHALL have port clk, input, 1, meaning system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port digits, input, 32, meaning eight hex nibbles; nibble 0 is digit register 1 (rightmost).
REQ-007 SHALL have port update, input, 1, meaning a one-cycle pulse that requests a display refresh from digits.
REQ-008 SHALL have port wr_req, input, 1, meaning host register-write request; held until wr_ack.
REQ-009 SHALL have ports wr_addr, input, 4, and wr_data, input, 8, meaning the MAX7219 register address and value.
REQ-010 SHALL have port wr_ack, output, 1, meaning a one-cycle pulse when the host frame has been latched by max_load.
REQ-011 SHALL have ports max_din, output, 1, max_clk, output, 1, and max_load, output, 1, meaning the MAX7219 pins.
REQ-012 SHALL have port init_done, output, 1, meaning the init sequence has completed; sticky until rst.
REQ-013 SHALL have port busy, output, 1, meaning a frame is in progress or an init or refresh sequence is active.

Function
REQ-014 Frame SHALL be 16 bits: address byte then data byte, MSB first; max_load low from the first max_clk low phase to the end of bit 15.
REQ-015 Each bit SHALL hold max_clk low CLK_DIV/2 cycles then high CLK_DIV/2 cycles; max_din SHALL change only while max_clk is low.
REQ-016 After bit 15, max_load SHALL rise and stay high LOAD_HOLD cycles before the next frame may start.
REQ-017 FSM states: INIT_SEND, IDLE, REFRESH_SEND, HOST_SEND, LOAD_GAP; after reset SHALL enter INIT_SEND.
REQ-018 Init SHALL send 6 frames in order: (0x0,0x00) no-op, (0xF,0x00) display test off, (0xB,0x07) scan limit, (0x9,0x00) no decode, (0xC,0x01) normal operation, (0xA,BRIGHTNESS).
REQ-019 Init SHALL then perform one full refresh with digits forced to 0; init_done SHALL rise one cycle after that refresh's final LOAD_GAP.
REQ-020 Refresh SHALL snapshot digits on entry and send addresses 1..8 with data = seg7(nibble); the update pulse SHALL be sampled in the same cycle.
REQ-021 seg7 SHALL be bit7=DP=0, bits6:0=A..G; 0=0x7E, 1=0x30, 2=0x6D, 3=0x79, 4=0x33, 5=0x5B, 6=0x5F, 7=0x70, 8=0x7F, 9=0x7B, A=0x77, b=0x1F, C=0x4E, d=0x3D, E=0x4F, F=0x47.
REQ-022 In IDLE, wr_req SHALL take priority over a pending refresh; between refresh frames, a pending wr_req SHALL be inserted before the next digit frame.
REQ-023 Frames SHALL never be preempted mid-frame.
REQ-024 wr_req asserted before init_done SHALL be held off until init completes; update pulses before init_done SHALL set the pending flag.
REQ-025 An update during a refresh SHALL set one pending flag (multiple updates coalesce); the pending refresh SHALL start after the current refresh's last frame.
REQ-026 The address sent SHALL be {4'h0, wr_addr}; wr_ack SHALL pulse in the cycle max_load rises for that frame.
REQ-027 busy SHALL be low only in IDLE with no pending refresh and wr_req low.

Reset
REQ-028 On rst: max_load=1, max_clk=0, max_din=0, wr_ack=0, init_done=0, busy=1, pending flag cleared, FSM=INIT_SEND at frame 0.
REQ-029 rst mid-frame SHALL abort the frame in the next cycle and restart the full init sequence.

Structure
REQ-030 Package max7219_pkg SHALL hold the register address constants, the FSM state enum, and the seg7 function.
REQ-031 Sub-module max7219_spi_tx16 SHALL contain the 16-bit shifter, bit counter, clock divider, and load timing, with a start/done handshake.
REQ-032 The top level SHALL contain only sequencing, arbitration, and the init table.

Verification
REQ-033 Reset release -> exactly 14 frames captured by a bench MAX7219 model; 6th frame is 0x0A0C; then digits 1..8 = 0x7E; init_done=1.
REQ-034 update with digits=0x89ABCDEF -> frames 0x01 47, 0x02 4F, ..., 0x08 7F in address order; busy falls LOAD_HOLD+1 cycles after the last load.
REQ-035 wr_req with addr=0xA, data=0x03 raised during the third refresh frame -> 0x0A03 sent as the fourth frame; one wr_ack pulse; refresh resumes at digit 4.
REQ-036 Three update pulses during one refresh -> exactly one follow-up refresh using the digits value sampled at its start.
REQ-037 rst at bit 7 of a frame -> max_load=1 next cycle, then the full init sequence restarts from the no-op frame.
REQ-038 Timing check, every frame: max_din stable while max_clk high; exactly 16 max_clk rising edges per max_load low window.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display controller: register addresses,
// sequencer state encoding, common bus typedefs and the hex-to-segment decoder.
// No ports; imported by the interface, the serial transmitter and the top level.
package max7219_pkg;

  typedef logic [31:0] digits_t;  // eight hex nibbles, nibble 0 = rightmost digit
  typedef logic [15:0] frame_t;   // {address byte, data byte}

  // MAX7219 register addresses (full address byte as shifted out)
  localparam logic [7:0] REG_NOOP       = 8'h00;
  localparam logic [7:0] REG_DIGIT0     = 8'h01;
  localparam logic [7:0] REG_DECODE     = 8'h09;
  localparam logic [7:0] REG_INTENSITY  = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] REG_DISP_TEST  = 8'h0F;

  // Number of configuration frames sent before the blanking refresh
  localparam int INIT_LEN = 6;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_INIT_SEND    = 3'd0;
  localparam state_t ST_IDLE         = 3'd1;
  localparam state_t ST_REFRESH_SEND = 3'd2;
  localparam state_t ST_HOST_SEND    = 3'd3;
  localparam state_t ST_LOAD_GAP     = 3'd4;

  // Hex nibble to segment pattern: bit7 = DP (always off), bits6:0 = A..G
  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'h7E;
      4'h1: seg = 8'h30;
      4'h2: seg = 8'h6D;
      4'h3: seg = 8'h79;
      4'h4: seg = 8'h33;
      4'h5: seg = 8'h5B;
      4'h6: seg = 8'h5F;
      4'h7: seg = 8'h70;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h7B;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h1F;
      4'hC: seg = 8'h4E;
      4'hD: seg = 8'h3D;
      4'hE: seg = 8'h4F;
      default: seg = 8'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/max7219_ctrl_if.sv
// Host-side bundle of the MAX7219 controller: digit value, refresh pulse,
// register-write handshake (wr_req held until wr_ack) and status flags.
// master = host logic, slave = controller.
interface max7219_ctrl_if;
  import max7219_pkg::*;

  digits_t     digits;     // eight hex nibbles, nibble 0 = digit register 1
  logic        update;     // one-cycle refresh request
  logic        wr_req;     // register write request, held until wr_ack
  logic [3:0]  wr_addr;    // MAX7219 register address
  logic [7:0]  wr_data;    // register value
  logic        wr_ack;     // pulses when the write frame is latched
  logic        init_done;  // sticky after power-up sequence completes
  logic        busy;       // low only when fully idle

  modport master (
    output digits, update, wr_req, wr_addr, wr_data,
    input  wr_ack, init_done, busy
  );

  modport slave (
    input  digits, update, wr_req, wr_addr, wr_data,
    output wr_ack, init_done, busy
  );

endinterface

// File: rtl/max7219_spi_tx16.sv
// 16-bit MSB-first serial transmitter for the MAX7219 (DIN/CLK/LOAD pins).
// Latency: frame takes 16*CLK_DIV cycles, then LOAD stays high LOAD_HOLD cycles.
// Backpressure: start is accepted only while idle; done marks the final frame cycle.
// Ports: clk/rst; start + frame in; idle, done out; max_din/max_clk/max_load pins.
module max7219_spi_tx16
  import max7219_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int LOAD_HOLD = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  frame_t frame,
  output logic   idle,
  output logic   done,
  output logic   max_din,
  output logic   max_clk,
  output logic   max_load
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int CNT_MAX = (CLK_DIV > LOAD_HOLD) ? CLK_DIV : LOAD_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] TX_HOLD  = 2'd2;

  logic [1:0]    ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  frame_t        sh_q, sh_d;
  logic          din_q, din_d;
  logic          sclk_q, sclk_d;
  logic          load_q, load_d;

  assign idle     = (ph_q == TX_IDLE);
  assign max_din  = din_q;
  assign max_clk  = sclk_q;
  assign max_load = load_q;

  always_comb begin
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    din_d  = din_q;
    sclk_d = sclk_q;
    load_d = load_q;
    done   = 1'b0;
    case (ph_q)
      TX_IDLE: begin
        if (start) begin
          // First bit is presented together with LOAD falling, clock low.
          ph_d   = TX_SHIFT;
          cnt_d  = '0;
          bit_d  = 4'd0;
          sh_d   = {frame[14:0], 1'b0};
          din_d  = frame[15];
          load_d = 1'b0;
          sclk_d = 1'b0;
        end
      end
      TX_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(HALF - 1)) begin
          sclk_d = 1'b1;
        end
        // DIN only moves on the same edge that drops the clock, so it is
        // stable for the whole high phase.
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            ph_d   = TX_HOLD;
            load_d = 1'b1;
            din_d  = 1'b0;
            done   = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            din_d = sh_q[15];
            sh_d  = {sh_q[14:0], 1'b0};
          end
        end
      end
      TX_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LOAD_HOLD - 1)) begin
          ph_d  = TX_IDLE;
          cnt_d = '0;
        end
      end
      default: ph_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= TX_IDLE;
      cnt_q  <= '0;
      bit_q  <= 4'd0;
      sh_q   <= '0;
      din_q  <= 1'b0;
      sclk_q <= 1'b0;
      load_q <= 1'b1;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      din_q  <= din_d;
      sclk_q <= sclk_d;
      load_q <= load_d;
    end
  end

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 controller: power-up init table, digit refresh and host register
// writes, arbitrated frame by frame onto one serial transmitter.
// Latency: refresh = 8 frames; a host write is inserted at the next frame boundary.
// Backpressure: wr_req held until wr_ack; update pulses coalesce into one pending flag.
// Ports: clk/rst; host (max7219_ctrl_if.slave); max_din/max_clk/max_load pins.
module max7219_ctrl
  import max7219_pkg::*;
#(
  parameter int CLK_DIV    = 10,
  parameter int BRIGHTNESS = 12,
  parameter int LOAD_HOLD  = 4
) (
  input  logic          clk,
  input  logic          rst,
  max7219_ctrl_if.slave host,
  output logic          max_din,
  output logic          max_clk,
  output logic          max_load
);

  localparam logic [7:0] INTENSITY = 8'(BRIGHTNESS % 16);

  state_t     state_q, state_d;
  logic [2:0] init_idx_q, init_idx_d;   // init frames already sent
  logic [3:0] dig_idx_q, dig_idx_d;     // next digit of the active refresh
  digits_t    snap_q, snap_d;           // digits captured at refresh entry
  logic       ref_act_q, ref_act_d;     // a refresh is part-way through
  logic       pend_q, pend_d;           // refresh requested but not started
  logic       init_done_q, init_done_d;
  logic       wr_ack_q, wr_ack_d;

  logic   tx_start;
  logic   tx_idle;
  logic   tx_done;
  frame_t tx_frame;

  function automatic frame_t init_frame(input logic [2:0] idx);
    frame_t f;
    case (idx)
      3'd0:    f = {REG_NOOP,       8'h00};
      3'd1:    f = {REG_DISP_TEST,  8'h00};
      3'd2:    f = {REG_SCAN_LIMIT, 8'h07};
      3'd3:    f = {REG_DECODE,     8'h00};
      3'd4:    f = {REG_SHUTDOWN,   8'h01};
      default: f = {REG_INTENSITY,  INTENSITY};
    endcase
    return f;
  endfunction

  assign host.wr_ack    = wr_ack_q;
  assign host.init_done = init_done_q;
  assign host.busy      = !(state_q == ST_IDLE && !pend_q && !host.wr_req);

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    dig_idx_d   = dig_idx_q;
    snap_d      = snap_q;
    ref_act_d   = ref_act_q;
    pend_d      = pend_q | host.update;
    init_done_d = init_done_q;
    wr_ack_d    = 1'b0;
    tx_start    = 1'b0;
    tx_frame    = '0;
    case (state_q)
      ST_INIT_SEND: begin
        tx_frame = init_frame(init_idx_q);
        tx_start = tx_idle;
        if (tx_done) begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = ST_LOAD_GAP;
        end
      end
      ST_REFRESH_SEND: begin
        tx_frame = {REG_DIGIT0 + {5'd0, dig_idx_q[2:0]},
                    seg7(snap_q[{dig_idx_q[2:0], 2'b00} +: 4])};
        tx_start = tx_idle;
        if (tx_done) begin
          dig_idx_d = dig_idx_q + 4'd1;
          state_d   = ST_LOAD_GAP;
        end
      end
      ST_HOST_SEND: begin
        tx_frame = {4'h0, host.wr_addr, host.wr_data};
        tx_start = tx_idle;
        // The ack register sets on the edge that raises LOAD for this frame.
        if (tx_done) begin
          wr_ack_d = 1'b1;
          state_d  = ST_LOAD_GAP;
        end
      end
      ST_LOAD_GAP: begin
        // Decide the next frame once the LOAD hold time has elapsed.
        if (tx_idle) begin
          if (init_idx_q != 3'(INIT_LEN)) begin
            state_d = ST_INIT_SEND;
          end else if (ref_act_q && dig_idx_q != 4'd8) begin
            state_d = (host.wr_req && init_done_q) ? ST_HOST_SEND : ST_REFRESH_SEND;
          end else if (!init_done_q && !ref_act_q) begin
            // Config table finished: blank all digits before going live.
            snap_d    = '0;
            dig_idx_d = 4'd0;
            ref_act_d = 1'b1;
            state_d   = ST_REFRESH_SEND;
          end else begin
            ref_act_d   = 1'b0;
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (host.wr_req && init_done_q) begin
          state_d = ST_HOST_SEND;
        end else if (pend_q || host.update) begin
          // An update arriving now is satisfied by this snapshot.
          snap_d    = host.digits;
          dig_idx_d = 4'd0;
          ref_act_d = 1'b1;
          pend_d    = 1'b0;
          state_d   = ST_REFRESH_SEND;
        end
      end
      default: state_d = ST_INIT_SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT_SEND;
      init_idx_q  <= 3'd0;
      dig_idx_q   <= 4'd0;
      snap_q      <= '0;
      ref_act_q   <= 1'b0;
      pend_q      <= 1'b0;
      init_done_q <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      dig_idx_q   <= dig_idx_d;
      snap_q      <= snap_d;
      ref_act_q   <= ref_act_d;
      pend_q      <= pend_d;
      init_done_q <= init_done_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  max7219_spi_tx16 #(
    .CLK_DIV  (CLK_DIV),
    .LOAD_HOLD(LOAD_HOLD)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (tx_start),
    .frame   (tx_frame),
    .idle    (tx_idle),
    .done    (tx_done),
    .max_din (max_din),
    .max_clk (max_clk),
    .max_load(max_load)
  );

endmodule

// File: tb/tb_max7219_ctrl.sv
// Bench for max7219_ctrl: a pin-level MAX7219 model captures frames, which are
// compared against frame lists built from the register map and segment table.
module tb_max7219_ctrl;

  localparam int CLK_DIV    = 10;
  localparam int BRIGHTNESS = 12;
  localparam int LOAD_HOLD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic max_din, max_clk, max_load;

  max7219_ctrl_if host();

  max7219_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .BRIGHTNESS(BRIGHTNESS),
    .LOAD_HOLD (LOAD_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host),
    .max_din (max_din),
    .max_clk (max_clk),
    .max_load(max_load)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] seg_tab [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                               8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47};

  // ---------------- pin-level display model ----------------
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] sr = '0;
  int   edges = 0;
  int   tim_err = 0;
  int   ack_cnt = 0;
  int   last_load_cyc = 0;
  logic p_sclk = 1'b0, p_din = 1'b0, p_load = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      edges = 0;  // any partial frame is discarded
    end else begin
      if (!p_sclk && max_clk) begin
        sr = {sr[14:0], max_din};
        edges++;
        if (max_load) tim_err++;
      end
      if (p_sclk && max_clk && (max_din !== p_din)) tim_err++;
      if (!p_load && max_load) begin
        got_q.push_back(sr);
        if (edges != 16) tim_err++;
        edges = 0;
        last_load_cyc = cyc;
      end
      if (host.wr_ack) begin
        ack_cnt++;
        if (!(!p_load && max_load)) tim_err++;
      end
    end
    p_sclk = max_clk;
    p_din  = max_din;
    p_load = max_load;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_update();
    host.update = 1'b1;
    tick();
    host.update = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!host.busy) begin
        fall = cyc;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (host.wr_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] digit_frame(input int i, input logic [31:0] d);
    logic [3:0] nib;
    nib = d[4*i +: 4];
    return {8'(i + 1), seg_tab[nib]};
  endfunction

  task automatic push_digits(input logic [31:0] d, input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(digit_frame(i, d));
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0C01);
    exp_q.push_back({8'h0A, 8'(BRIGHTNESS)});
    push_digits(32'h0, 0, 7);
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_f%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d, d2;
    logic [3:0]  wa;
    logic [7:0]  wd;
    int   fall, acks0;
    bit   ok;

    host.digits  = '0;
    host.update  = 1'b0;
    host.wr_req  = 1'b0;
    host.wr_addr = '0;
    host.wr_data = '0;

    // reset state
    rst = 1'b1;
    ticks(3);
    chk("rst_load",      32'(max_load),       32'd1);
    chk("rst_sclk",      32'(max_clk),        32'd0);
    chk("rst_din",       32'(max_din),        32'd0);
    chk("rst_ack",       32'(host.wr_ack),    32'd0);
    chk("rst_init_done", 32'(host.init_done), 32'd0);
    chk("rst_busy",      32'(host.busy),      32'd1);
    rst = 1'b0;

    // power-up sequence: 6 config frames + blanking refresh
    wait_idle(6000, fall);
    chk("init_finish", 32'(fall >= 0), 32'd1);
    chk("init_done", 32'(host.init_done), 32'd1);
    push_init();
    cmp_frames("init");

    // plain refreshes, first one with a fixed pattern
    for (int r = 0; r < 3; r++) begin
      d = (r == 0) ? 32'h89ABCDEF : $urandom;
      host.digits = d;
      pulse_update();
      host.digits = $urandom;   // snapshot must already be taken
      push_digits(d, 0, 7);
      wait_idle(3000, fall);
      chk("ref_finish", 32'(fall >= 0), 32'd1);
      cmp_frames("ref");
      chk("ref_busy_fall", 32'(fall - last_load_cyc), 32'(LOAD_HOLD + 1));
    end

    // host write raised during the third refresh frame
    d = $urandom;
    host.digits = d;
    pulse_update();
    host.digits = $urandom;
    wait_frames(2, 1000, ok);
    chk("ins_two_frames", 32'(ok), 32'd1);
    ticks(20);
    acks0 = ack_cnt;
    host.wr_addr = 4'hA;
    host.wr_data = 8'h03;
    host.wr_req  = 1'b1;
    wait_ack(1000, ok);
    host.wr_req  = 1'b0;
    chk("ins_ack_seen", 32'(ok), 32'd1);
    wait_idle(3000, fall);
    chk("ins_finish", 32'(fall >= 0), 32'd1);
    push_digits(d, 0, 2);
    exp_q.push_back(16'h0A03);
    push_digits(d, 3, 7);
    cmp_frames("ins");
    chk("ins_acks", 32'(ack_cnt - acks0), 32'd1);

    // random host write from idle
    wa = 4'($urandom);
    wd = 8'($urandom);
    acks0 = ack_cnt;
    host.wr_addr = wa;
    host.wr_data = wd;
    host.wr_req  = 1'b1;
    #1;
    chk("host_busy", 32'(host.busy), 32'd1);
    wait_ack(1000, ok);
    host.wr_req = 1'b0;
    chk("host_ack_seen", 32'(ok), 32'd1);
    wait_idle(1000, fall);
    exp_q.push_back({4'h0, wa, wd});
    cmp_frames("host");
    chk("host_acks", 32'(ack_cnt - acks0), 32'd1);

    // three updates during one refresh coalesce into one follow-up
    d = $urandom;
    host.digits = d;
    pulse_update();
    host.digits = $urandom;
    wait_frames(1, 1000, ok);
    ticks(10);
    pulse_update();
    host.digits = $urandom;
    ticks(200);
    pulse_update();
    ticks(300);
    d2 = $urandom;
    host.digits = d2;
    pulse_update();
    wait_idle(6000, fall);
    chk("coal_finish", 32'(fall >= 0), 32'd1);
    push_digits(d, 0, 7);
    push_digits(d2, 0, 7);
    cmp_frames("coal");

    // reset in bit 7 of a frame, then requests queued before init completes
    d = $urandom;
    host.digits = d;
    pulse_update();
    wait_frames(1, 1000, ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!max_load) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_frame_start", 32'(ok), 32'd1);
    ticks(7 * CLK_DIV + 2);
    rst = 1'b1;
    tick();
    chk("rst_mid_load", 32'(max_load), 32'd1);
    chk("rst_mid_sclk", 32'(max_clk), 32'd0);
    ticks(2);
    rst = 1'b0;
    got_q.delete();
    ticks(30);
    chk("rst_mid_busy", 32'(host.busy), 32'd1);
    wa = 4'($urandom);
    wd = 8'($urandom);
    d  = $urandom;
    acks0 = ack_cnt;
    host.wr_addr = wa;
    host.wr_data = wd;
    host.wr_req  = 1'b1;
    host.digits  = d;
    pulse_update();
    chk("pre_init_done", 32'(host.init_done), 32'd0);
    wait_ack(6000, ok);
    host.wr_req = 1'b0;
    chk("reinit_ack_seen", 32'(ok), 32'd1);
    wait_idle(3000, fall);
    chk("reinit_finish", 32'(fall >= 0), 32'd1);
    push_init();
    exp_q.push_back({4'h0, wa, wd});
    push_digits(d, 0, 7);
    cmp_frames("reinit");
    chk("reinit_acks", 32'(ack_cnt - acks0), 32'd1);
    chk("reinit_done", 32'(host.init_done), 32'd1);

    chk("pin_timing", 32'(tim_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
